sine_wave_gen: RTL and testbench
================================

# sine_wave_gen

Table-driven sine-wave source: a programmable clock-enable divider advances a 6-bit phase accumulator through a 64-entry, 8-bit sine ROM, and the sample is re-registered as the output word. The block sits in the single `clk_in` domain and feeds a DAC or PWM stage, or any consumer of 8-bit unsigned samples.

## Interface
- `CLK_DIV`, default 4: `clk_in` cycles per sample step; legal range 1..2^24.
- `clk_in`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `lut_out`  out  8  registered ROM read data, one step ahead of `sine`.
- `sine`  out  8  output sample, unsigned offset-binary.
- `phase`  out  6  current ROM address, for debug and verification.

## Operation
- Divider:
  - Counter `div_cnt` runs 0..`CLK_DIV`-1.
  - `tick` = (`div_cnt` == `CLK_DIV`-1); on `tick` the counter wraps to 0.
  - With `CLK_DIV`=1, `tick` is high every cycle.
  - `tick` is an enable only; no derived or gated clocks.
- On each `tick`, in the same edge:
  - `lut_out` <= ROM[`phase`].
  - `sine` <= `lut_out`, i.e. the old value.
  - `phase` <= `phase`+1, modulo 64.
- Between ticks all registers hold.
- ROM:
  - ROM[k] = round(128 + 127·sin(2πk/64)), k = 0..63; range 1..255.
  - Key entries: [0]=128, [1]=140, [2]=153, [4]=177, [8]=218, [16]=255, [24]=218, [32]=128, [40]=38, [48]=1, [56]=38.
  - Contents are constant and synthesize to LUT or BRAM.
- Phase wrap: 63 -> 0 with no skipped or repeated sample. The period is 64 ticks = 64·`CLK_DIV` clocks.

## Timing
- Reset (`rst`=1 at an edge) forces `div_cnt`=0, `phase`=0, `lut_out`=0, `sine`=0.
- Reset has priority over `tick`. Reset mid-period restarts the waveform at phase 0 with no residual samples.
- First `tick` is on the `CLK_DIV`-th rising edge after the first edge with `rst`=0.
- Latency:
  - `lut_out` shows ROM[n] one tick after `phase`=n.
  - `sine` shows ROM[n] two ticks after `phase`=n.
- Post-reset output sequence at successive ticks:
  - `lut_out`: 128, 140, 153, …
  - `sine`: 0, 128, 140, 153, …
- Outputs change only on `tick` edges. Each value is stable for exactly `CLK_DIV` clocks in steady state.

## Structure
- Shared package `sine_pkg`:
  - `LUT_DEPTH`=64, `ADDR_W`=6, `DATA_W`=8.
  - Sample typedef `logic [DATA_W-1:0]`.
  - Constant ROM table (64 entries, values per formula above).
- One sub-module: `sine_rom`, a synchronous 64×8 ROM.
  - Ports: `clk_in`, `en`, `addr[5:0]`, `dout[7:0]`.
  - Registered read, updated only when `en`=1.
  - Cleared by `rst`.
- Divider counter and phase register live in the top.

## Test plan
- Reset: hold `rst` 3 clocks mid-run -> next edge shows `sine`=0, `lut_out`=0, `phase`=0; counter restarts, first tick 4 clocks after release (`CLK_DIV`=4).
- Divider: `CLK_DIV`=4 -> `phase` increments exactly every 4 clocks. `CLK_DIV`=1 -> `phase` increments every clock, and `sine` sequence 0,128,140,153 appears on consecutive clocks.
- Latency: after reset, ticks 1..4 give `lut_out`=128,140,153,165 and `sine`=0,128,140,153.
- Quarter points: capture one period of `sine` -> samples at phases 0/16/32/48 equal 128/255/128/1. Min is 1, max is 255, and the waveform is symmetric (ROM[k] + ROM[k+32] = 256).
- Wrap: run 130 ticks -> `phase` goes 63 -> 0. The `sine` sequence around the wrap is ROM[62], ROM[63], ROM[0], ROM[1]. Samples of period 2 match period 1 exactly.
- Reset mid-period: assert `rst` at `phase`=37 -> after release the sequence restarts 0,128,140 with no stale value from phase 36/37.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared widths, sample type and the constant 64-entry sine table.
package sine_pkg;

  localparam int unsigned LUT_DEPTH = 64;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DATA_W    = 8;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // round(128 + 127*sin(2*pi*k/64)); second half mirrors the first about 128
  localparam sample_t ROM_TABLE [LUT_DEPTH] = '{
    8'd128, 8'd140, 8'd153, 8'd165, 8'd177, 8'd188, 8'd199, 8'd209,
    8'd218, 8'd226, 8'd234, 8'd240, 8'd245, 8'd250, 8'd253, 8'd254,
    8'd255, 8'd254, 8'd253, 8'd250, 8'd245, 8'd240, 8'd234, 8'd226,
    8'd218, 8'd209, 8'd199, 8'd188, 8'd177, 8'd165, 8'd153, 8'd140,
    8'd128, 8'd116, 8'd103, 8'd91,  8'd79,  8'd68,  8'd57,  8'd47,
    8'd38,  8'd30,  8'd22,  8'd16,  8'd11,  8'd6,   8'd3,   8'd2,
    8'd1,   8'd2,   8'd3,   8'd6,   8'd11,  8'd16,  8'd22,  8'd30,
    8'd38,  8'd47,  8'd57,  8'd68,  8'd79,  8'd91,  8'd103, 8'd116
  };

endpackage

// File: rtl/sine_rom.sv
// Synchronous 64x8 sine ROM; read data registered and updated only when enabled.
module sine_rom
  import sine_pkg::*;
(
  input  logic    clk_in,
  input  logic    rst,
  input  logic    en,
  input  addr_t   addr,
  output sample_t dout
);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      dout <= '0;
    end else if (en) begin
      dout <= ROM_TABLE[addr];
    end
  end

endmodule

// File: rtl/sine_wave_gen.sv
// Table-driven sine source: clock-enable divider steps a phase accumulator through the ROM.
module sine_wave_gen
  import sine_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  output logic [DATA_W-1:0] lut_out,
  output logic [DATA_W-1:0] sine,
  output logic [ADDR_W-1:0] phase
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  addr_t            phase_q, phase_d;
  sample_t          sine_q, sine_d;
  sample_t          lut_q;
  logic             tick_c;

  // Divider, phase step and output pipeline advance together on tick only
  always_comb begin
    tick_c    = (div_cnt_q == CNT_LAST);
    div_cnt_d = div_cnt_q + CNT_W'(1);
    phase_d   = phase_q;
    sine_d    = sine_q;
    if (tick_c) begin
      div_cnt_d = '0;
      phase_d   = phase_q + ADDR_W'(1);
      sine_d    = lut_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_cnt_q <= '0;
      phase_q   <= '0;
      sine_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      sine_q    <= sine_d;
    end
  end

  sine_rom u_rom (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (tick_c),
    .addr   (phase_q),
    .dout   (lut_q)
  );

  assign lut_out = lut_q;
  assign sine    = sine_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_sine_wave_gen.sv
// Self-checking bench: three divider settings against a closed-form tick/sample model.
module tb_sine_wave_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] lut4, sine4, lut1, sine1, lut7, sine7;
  logic [5:0] ph4, ph1, ph7;

  always #5 clk = ~clk;

  sine_wave_gen #(.CLK_DIV(4)) u_dut4 (.clk_in(clk), .rst(rst), .lut_out(lut4), .sine(sine4), .phase(ph4));
  sine_wave_gen #(.CLK_DIV(1)) u_dut1 (.clk_in(clk), .rst(rst), .lut_out(lut1), .sine(sine1), .phase(ph1));
  sine_wave_gen #(.CLK_DIV(7)) u_dut7 (.clk_in(clk), .rst(rst), .lut_out(lut7), .sine(sine7), .phase(ph7));

  int n_tests = 0;
  int n_fail  = 0;
  int rom_ref [64];
  int quarter [4];
  int lat_lut [4];
  int lat_sine[4];
  int e4 = 0, e1 = 0, e7 = 0;
  int min4 = 999, max4 = -1;
  bit chk_en = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: ticks elapsed = edges since reset / divider; lut lags phase by one tick, sine by two
  function automatic int m_phase(input int e, input int d);
    return (e / d) % 64;
  endfunction

  function automatic int m_lut(input int e, input int d);
    int t = e / d;
    return (t >= 1) ? rom_ref[(t - 1) % 64] : 0;
  endfunction

  function automatic int m_sine(input int e, input int d);
    int t = e / d;
    return (t >= 2) ? rom_ref[(t - 2) % 64] : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e4 <= 0; e1 <= 0; e7 <= 0;
    end else begin
      e4 <= e4 + 1; e1 <= e1 + 1; e7 <= e7 + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("d4_phase", int'(ph4),   m_phase(e4, 4));
      check_val("d4_lut",   int'(lut4),  m_lut(e4, 4));
      check_val("d4_sine",  int'(sine4), m_sine(e4, 4));
      check_val("d1_phase", int'(ph1),   m_phase(e1, 1));
      check_val("d1_lut",   int'(lut1),  m_lut(e1, 1));
      check_val("d1_sine",  int'(sine1), m_sine(e1, 1));
      check_val("d7_phase", int'(ph7),   m_phase(e7, 7));
      check_val("d7_lut",   int'(lut7),  m_lut(e7, 7));
      check_val("d7_sine",  int'(sine7), m_sine(e7, 7));
      if ((e4 / 4) >= 2) begin
        if (((e4 / 4 - 2) % 16) == 0)
          check_val("quarter", int'(sine4), quarter[((e4 / 4 - 2) / 16) % 4]);
        if (int'(sine4) < min4) min4 = int'(sine4);
        if (int'(sine4) > max4) max4 = int'(sine4);
      end
    end
  end

  initial begin
    for (int k = 0; k < 64; k++)
      rom_ref[k] = int'($floor(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 64.0) + 0.5));
    quarter  = '{128, 255, 128, 1};
    lat_lut  = '{128, 140, 153, 165};
    lat_sine = '{0, 128, 140, 153};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_val("rst_sine", int'(sine4), 0);
    check_val("rst_lut",  int'(lut4),  0);
    check_val("rst_phase", int'(ph4),  0);
    rst = 1'b0;

    // Post-reset latency: D=1 on consecutive clocks, D=4 every fourth clock
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        check_val("lat1_lut",  int'(lut1),  lat_lut[k-1]);
        check_val("lat1_sine", int'(sine1), lat_sine[k-1]);
      end
      if ((k % 4) == 0) begin
        check_val("lat4_lut",  int'(lut4),  lat_lut[k/4-1]);
        check_val("lat4_sine", int'(sine4), lat_sine[k/4-1]);
        check_val("lat4_phase", int'(ph4),  k / 4);
      end
    end

    repeat (600) @(negedge clk);

    // Reset mid-period at phase 37
    begin
      int n = 0;
      while (ph4 != 6'd37 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check_val("wait_phase37", int'(ph4), 37);
    end
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_sine",  int'(sine4), 0);
    check_val("mid_rst_lut",   int'(lut4),  0);
    check_val("mid_rst_phase", int'(ph4),   0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      check_val("restart_sine", int'(sine4), lat_sine[i]);
    end

    // Random reset pulses at random points
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(50, 300)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end

    // Long run: more than two periods at D=4, many wraps at D=1 and D=7
    repeat (700) @(negedge clk);
    check_val("min_sample", min4, 1);
    check_val("max_sample", max4, 255);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
